// File: rtl/c7bbiu_rd_arb_pkg.sv
// Shared AXI encodings and arbiter state type for the BIU read arbiter.
package c7bbiu_rd_arb_pkg;

  localparam logic [3:0] AXI_RID_IFU    = 4'h0;
  localparam logic [3:0] AXI_RID_LSU    = 4'h1;
  localparam logic [2:0] AXI_SIZE_WORD  = 3'b010;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  typedef enum logic {
    AR_IDLE  = 1'b0,
    AR_ISSUE = 1'b1
  } ar_state_e;

endpackage

// File: rtl/c7bbiu_rd_arb_track.sv
// Per-requester read tracker: one outstanding burst, beat counter and
// routed val/data/last/err for the R beats carrying this tracker's RID.
module c7bbiu_rd_track
  import c7bbiu_rd_arb_pkg::*;
#(
  parameter logic [3:0] RID = 4'h0,
  parameter logic [7:0] LEN = 8'd0
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        set_pend,
  input  logic        r_valid,
  input  logic [3:0]  r_id,
  input  logic [31:0] r_data,
  input  logic [1:0]  r_resp,
  input  logic        r_last,
  output logic        pend,
  output logic        rd_val,
  output logic [31:0] rd_data,
  output logic        rd_last,
  output logic        rd_err
);

  logic       pend_q, pend_d;
  logic [7:0] cnt_q, cnt_d;
  logic       ovr_q, ovr_d;
  logic       hit;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      pend_q <= 1'b0;
      cnt_q  <= 8'd0;
      ovr_q  <= 1'b0;
    end else begin
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
      ovr_q  <= ovr_d;
    end
  end

  // Once a burst overruns its length, every beat until r_last is flagged.
  always_comb begin
    hit    = r_valid & (r_id == RID) & pend_q;
    pend_d = pend_q;
    cnt_d  = cnt_q;
    ovr_d  = ovr_q;
    if (set_pend) begin
      pend_d = 1'b1;
      cnt_d  = 8'd0;
      ovr_d  = 1'b0;
    end else if (hit) begin
      if (r_last) begin
        pend_d = 1'b0;
        cnt_d  = 8'd0;
        ovr_d  = 1'b0;
      end else begin
        cnt_d = cnt_q + 8'd1;
        if (cnt_q == LEN) ovr_d = 1'b1;
      end
    end
  end

  assign pend    = pend_q;
  assign rd_val  = hit;
  assign rd_data = hit ? r_data : 32'd0;
  assign rd_last = hit & r_last;
  assign rd_err  = hit & ((r_resp != AXI_RESP_OKAY) | (r_last & (cnt_q != LEN)) |
                          (~r_last & (cnt_q == LEN)) | ovr_q);

endmodule

// File: rtl/c7bbiu_rd_arb.sv
// BIU read arbiter: round-robin IFU/LSU onto one AXI AR channel and
// route R beats back to the owning requester by RID.
module c7bbiu_rd_arb
  import c7bbiu_rd_arb_pkg::*;
#(
  parameter logic [7:0] IFU_LEN = 8'd3,
  parameter logic [7:0] LSU_LEN = 8'd0
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        ifu_biu_rd_req,
  input  logic [31:0] ifu_biu_rd_addr,
  output logic        biu_ifu_rd_ack,
  output logic        biu_ifu_rd_val,
  output logic [31:0] biu_ifu_rd_data,
  output logic        biu_ifu_rd_last,
  output logic        biu_ifu_rd_err,
  input  logic        lsu_biu_rd_req,
  input  logic [31:0] lsu_biu_rd_addr,
  output logic        biu_lsu_rd_ack,
  output logic        biu_lsu_rd_val,
  output logic [31:0] biu_lsu_rd_data,
  output logic        biu_lsu_rd_last,
  output logic        biu_lsu_rd_err,
  output logic        axi_ar_valid,
  input  logic        axi_ar_ready,
  output logic [3:0]  axi_ar_id,
  output logic [31:0] axi_ar_addr,
  output logic [7:0]  axi_ar_len,
  output logic [2:0]  axi_ar_size,
  output logic [1:0]  axi_ar_burst,
  output logic        axi_ar_lock,
  output logic [3:0]  axi_ar_cache,
  output logic [2:0]  axi_ar_prot,
  input  logic        axi_r_valid,
  output logic        axi_r_ready,
  input  logic [3:0]  axi_r_id,
  input  logic [31:0] axi_r_data,
  input  logic [1:0]  axi_r_resp,
  input  logic        axi_r_last
);

  ar_state_e   state_q, state_d;
  logic        prio_ifu_q, prio_ifu_d;
  logic        owner_lsu_q, owner_lsu_d;
  logic [3:0]  ar_id_q, ar_id_d;
  logic [31:0] ar_addr_q, ar_addr_d;
  logic [7:0]  ar_len_q, ar_len_d;
  logic        ifu_set, lsu_set, ifu_pend, lsu_pend;
  logic        elig_ifu, elig_lsu, pick_lsu;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= AR_IDLE;
      prio_ifu_q  <= 1'b0;
      owner_lsu_q <= 1'b0;
      ar_id_q     <= 4'd0;
      ar_addr_q   <= 32'd0;
      ar_len_q    <= 8'd0;
    end else begin
      state_q     <= state_d;
      prio_ifu_q  <= prio_ifu_d;
      owner_lsu_q <= owner_lsu_d;
      ar_id_q     <= ar_id_d;
      ar_addr_q   <= ar_addr_d;
      ar_len_q    <= ar_len_d;
    end
  end

  assign elig_ifu = ifu_biu_rd_req & ~ifu_pend;
  assign elig_lsu = lsu_biu_rd_req & ~lsu_pend;
  assign pick_lsu = elig_lsu & (~elig_ifu | ~prio_ifu_q);

  always_comb begin
    state_d     = state_q;
    prio_ifu_d  = prio_ifu_q;
    owner_lsu_d = owner_lsu_q;
    ar_id_d     = ar_id_q;
    ar_addr_d   = ar_addr_q;
    ar_len_d    = ar_len_q;
    ifu_set     = 1'b0;
    lsu_set     = 1'b0;
    case (state_q)
      AR_IDLE: begin
        if (elig_ifu | elig_lsu) begin
          state_d     = AR_ISSUE;
          owner_lsu_d = pick_lsu;
          ar_id_d     = pick_lsu ? AXI_RID_LSU : AXI_RID_IFU;
          ar_addr_d   = pick_lsu ? lsu_biu_rd_addr : ifu_biu_rd_addr;
          ar_len_d    = pick_lsu ? LSU_LEN : IFU_LEN;
        end
      end
      AR_ISSUE: begin
        // The loser of this grant gets priority on the next tie.
        if (axi_ar_ready) begin
          state_d    = AR_IDLE;
          ifu_set    = ~owner_lsu_q;
          lsu_set    = owner_lsu_q;
          prio_ifu_d = owner_lsu_q;
        end
      end
      default: state_d = AR_IDLE;
    endcase
  end

  assign axi_ar_valid   = (state_q == AR_ISSUE);
  assign axi_ar_id      = ar_id_q;
  assign axi_ar_addr    = ar_addr_q;
  assign axi_ar_len     = ar_len_q;
  assign axi_ar_size    = AXI_SIZE_WORD;
  assign axi_ar_burst   = AXI_BURST_INCR;
  assign axi_ar_lock    = 1'b0;
  assign axi_ar_cache   = 4'd0;
  assign axi_ar_prot    = 3'd0;
  assign axi_r_ready    = 1'b1;
  assign biu_ifu_rd_ack = ifu_set;
  assign biu_lsu_rd_ack = lsu_set;

  c7bbiu_rd_track #(.RID(AXI_RID_IFU), .LEN(IFU_LEN)) u_ifu_track (
    .clk(clk), .resetn(resetn), .set_pend(ifu_set),
    .r_valid(axi_r_valid), .r_id(axi_r_id), .r_data(axi_r_data),
    .r_resp(axi_r_resp), .r_last(axi_r_last), .pend(ifu_pend),
    .rd_val(biu_ifu_rd_val), .rd_data(biu_ifu_rd_data),
    .rd_last(biu_ifu_rd_last), .rd_err(biu_ifu_rd_err)
  );

  c7bbiu_rd_track #(.RID(AXI_RID_LSU), .LEN(LSU_LEN)) u_lsu_track (
    .clk(clk), .resetn(resetn), .set_pend(lsu_set),
    .r_valid(axi_r_valid), .r_id(axi_r_id), .r_data(axi_r_data),
    .r_resp(axi_r_resp), .r_last(axi_r_last), .pend(lsu_pend),
    .rd_val(biu_lsu_rd_val), .rd_data(biu_lsu_rd_data),
    .rd_last(biu_lsu_rd_last), .rd_err(biu_lsu_rd_err)
  );

endmodule

// File: tb/tb_c7bbiu_rd_arb.sv
// Directed self-checking bench for c7bbiu_rd_arb; inputs change 1 time unit
// after the rising edge and outputs are checked 2 units later.
module tb_c7bbiu_rd_arb;

  localparam logic [3:0] RID_IFU = 4'h0;
  localparam logic [3:0] RID_LSU = 4'h1;

  logic        clk = 1'b0;
  logic        resetn;
  logic        ifu_req, lsu_req;
  logic [31:0] ifu_addr, lsu_addr;
  logic        ifu_ack, ifu_val, ifu_last, ifu_err;
  logic        lsu_ack, lsu_val, lsu_last, lsu_err;
  logic [31:0] ifu_data, lsu_data;
  logic        ar_valid, ar_ready, ar_lock;
  logic [3:0]  ar_id, ar_cache;
  logic [31:0] ar_addr;
  logic [7:0]  ar_len;
  logic [2:0]  ar_size, ar_prot;
  logic [1:0]  ar_burst;
  logic        r_valid, r_ready, r_last;
  logic [3:0]  r_id;
  logic [31:0] r_data;
  logic [1:0]  r_resp;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  c7bbiu_rd_arb dut (
    .clk(clk), .resetn(resetn),
    .ifu_biu_rd_req(ifu_req), .ifu_biu_rd_addr(ifu_addr),
    .biu_ifu_rd_ack(ifu_ack), .biu_ifu_rd_val(ifu_val), .biu_ifu_rd_data(ifu_data),
    .biu_ifu_rd_last(ifu_last), .biu_ifu_rd_err(ifu_err),
    .lsu_biu_rd_req(lsu_req), .lsu_biu_rd_addr(lsu_addr),
    .biu_lsu_rd_ack(lsu_ack), .biu_lsu_rd_val(lsu_val), .biu_lsu_rd_data(lsu_data),
    .biu_lsu_rd_last(lsu_last), .biu_lsu_rd_err(lsu_err),
    .axi_ar_valid(ar_valid), .axi_ar_ready(ar_ready), .axi_ar_id(ar_id),
    .axi_ar_addr(ar_addr), .axi_ar_len(ar_len), .axi_ar_size(ar_size),
    .axi_ar_burst(ar_burst), .axi_ar_lock(ar_lock), .axi_ar_cache(ar_cache),
    .axi_ar_prot(ar_prot),
    .axi_r_valid(r_valid), .axi_r_ready(r_ready), .axi_r_id(r_id),
    .axi_r_data(r_data), .axi_r_resp(r_resp), .axi_r_last(r_last)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [3:0] id, input logic [31:0] data,
                      input logic [1:0] resp, input logic last);
    cyc();
    r_valid = 1'b1; r_id = id; r_data = data; r_resp = resp; r_last = last;
    #2;
    $display("R beat id=%h data=%h resp=%0d last=%0b -> ifu val=%0b err=%0b lsu val=%0b err=%0b",
             id, data, resp, last, ifu_val, ifu_err, lsu_val, lsu_err);
  endtask

  task automatic rclr();
    cyc();
    r_valid = 1'b0; r_last = 1'b0; r_resp = 2'b00;
  endtask

  // Checks both ports for one beat; data/last/err checked on the expected owner.
  task automatic chk_beat(input string tag, input logic exp_iv, input logic exp_lv,
                          input logic exp_last, input logic exp_err, input logic [31:0] exp_data);
    chk({tag, "_ifu_val"}, ifu_val, exp_iv);
    chk({tag, "_lsu_val"}, lsu_val, exp_lv);
    if (exp_iv) begin
      chk({tag, "_ifu_data"}, ifu_data, exp_data);
      chk({tag, "_ifu_last"}, ifu_last, exp_last);
      chk({tag, "_ifu_err"}, ifu_err, exp_err);
    end
    if (exp_lv) begin
      chk({tag, "_lsu_data"}, lsu_data, exp_data);
      chk({tag, "_lsu_last"}, lsu_last, exp_last);
      chk({tag, "_lsu_err"}, lsu_err, exp_err);
    end
  endtask

  // Single requester grant with ar_ready=1; bounded wait for the ack.
  task automatic grant(input logic is_lsu, input logic [31:0] addr, input string tag);
    int n;
    cyc();
    ar_ready = 1'b1;
    if (is_lsu) begin lsu_req = 1'b1; lsu_addr = addr; end
    else begin ifu_req = 1'b1; ifu_addr = addr; end
    #2;
    n = 0;
    while (!(is_lsu ? lsu_ack : ifu_ack) && n < 8) begin
      cyc(); #2; n++;
    end
    chk({tag, "_ack"}, is_lsu ? lsu_ack : ifu_ack, 1'b1);
    chk({tag, "_id"}, ar_id, is_lsu ? RID_LSU : RID_IFU);
    chk({tag, "_addr"}, ar_addr, addr);
    chk({tag, "_len"}, ar_len, is_lsu ? 8'd0 : 8'd3);
    $display("AR grant %s id=%h addr=%h len=%0d", tag, ar_id, ar_addr, ar_len);
    cyc();
    if (is_lsu) lsu_req = 1'b0; else ifu_req = 1'b0;
  endtask

  initial begin
    resetn = 1'b0; ifu_req = 1'b0; lsu_req = 1'b0; ifu_addr = 32'd0; lsu_addr = 32'd0;
    ar_ready = 1'b0; r_valid = 1'b0; r_id = 4'd0; r_data = 32'd0; r_resp = 2'b00; r_last = 1'b0;
    cyc(); cyc();
    #2;
    chk("rst_ar_valid", ar_valid, 1'b0);
    chk("rst_ifu_ack", ifu_ack, 1'b0);
    chk("rst_lsu_ack", lsu_ack, 1'b0);
    chk("rst_ar_addr", ar_addr, 32'd0);
    cyc();
    resetn = 1'b1;

    // Tie straight after reset: LSU first, IFU two cycles later.
    cyc();
    ifu_req = 1'b1; ifu_addr = 32'h100; lsu_req = 1'b1; lsu_addr = 32'h200; ar_ready = 1'b1;
    #2; chk("tie1_pick_arv", ar_valid, 1'b0);
    cyc(); #2;
    chk("tie1_a_arv", ar_valid, 1'b1);
    chk("tie1_a_id", ar_id, RID_LSU);
    chk("tie1_a_lack", lsu_ack, 1'b1);
    chk("tie1_a_iack", ifu_ack, 1'b0);
    $display("AR grant tie1 first id=%h", ar_id);
    cyc(); lsu_req = 1'b0; #2;
    chk("tie1_gap_arv", ar_valid, 1'b0);
    cyc(); #2;
    chk("tie1_b_id", ar_id, RID_IFU);
    chk("tie1_b_addr", ar_addr, 32'h100);
    chk("tie1_b_iack", ifu_ack, 1'b1);
    $display("AR grant tie1 second id=%h", ar_id);
    cyc(); ifu_req = 1'b0;
    beat(RID_LSU, 32'h11, 2'b00, 1'b1); chk_beat("tie1_l0", 0, 1, 1, 0, 32'h11);
    for (int i = 0; i < 4; i++) begin
      beat(RID_IFU, 32'h20 + i, 2'b00, i == 3);
      chk_beat("tie1_i", 1, 0, i == 3, 0, 32'h20 + i);
    end
    rclr();

    // LSU single read, ack in the ar_valid cycle.
    lsu_req = 1'b1; lsu_addr = 32'h1000; #2;
    chk("lsu_pick_arv", ar_valid, 1'b0);
    cyc(); #2;
    chk("lsu_arv", ar_valid, 1'b1);
    chk("lsu_id", ar_id, RID_LSU);
    chk("lsu_len", ar_len, 8'd0);
    chk("lsu_addr", ar_addr, 32'h1000);
    chk("lsu_size", ar_size, 3'b010);
    chk("lsu_burst", ar_burst, 2'b01);
    chk("lsu_ack", lsu_ack, 1'b1);
    cyc(); lsu_req = 1'b0; #2;
    chk("lsu_post_arv", ar_valid, 1'b0);
    chk("lsu_rready", r_ready, 1'b1);
    beat(RID_LSU, 32'hCAFEF00D, 2'b00, 1'b1); chk_beat("lsu_b0", 0, 1, 1, 0, 32'hCAFEF00D);
    beat(RID_LSU, 32'hCAFEF00D, 2'b00, 1'b1); chk_beat("lsu_stale", 0, 0, 0, 0, 32'h0);
    rclr();

    // Tie after an LSU grant: IFU wins.
    ifu_req = 1'b1; ifu_addr = 32'h300; lsu_req = 1'b1; lsu_addr = 32'h400;
    cyc(); #2;
    chk("tie2_a_id", ar_id, RID_IFU);
    chk("tie2_a_iack", ifu_ack, 1'b1);
    cyc(); ifu_req = 1'b0;
    cyc(); #2;
    chk("tie2_b_id", ar_id, RID_LSU);
    chk("tie2_b_lack", lsu_ack, 1'b1);
    cyc(); lsu_req = 1'b0;
    beat(RID_LSU, 32'h44, 2'b00, 1'b1); chk_beat("tie2_l0", 0, 1, 1, 0, 32'h44);
    for (int i = 0; i < 4; i++) begin
      beat(RID_IFU, 32'h30 + i, 2'b00, i == 3);
      chk_beat("tie2_i", 1, 0, i == 3, 0, 32'h30 + i);
    end
    rclr();

    // IFU burst with ar_ready stalled for 5 cycles.
    ar_ready = 1'b0; ifu_req = 1'b1; ifu_addr = 32'h2000;
    for (int i = 0; i < 5; i++) begin
      cyc(); #2;
      chk("stall_arv", ar_valid, 1'b1);
      chk("stall_addr", ar_addr, 32'h2000);
      chk("stall_len", ar_len, 8'd3);
      chk("stall_ack", ifu_ack, 1'b0);
    end
    cyc(); ar_ready = 1'b1; #2;
    chk("stall_hs_ack", ifu_ack, 1'b1);
    cyc(); ifu_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      beat(RID_IFU, 32'hD0 + i, 2'b00, i == 3);
      chk_beat("burst", 1, 0, i == 3, 0, 32'hD0 + i);
    end
    rclr();
    grant(1'b0, 32'h3000, "ifu_again");

    // Interleaved IFU and LSU beats.
    grant(1'b1, 32'h1004, "lsu_il");
    beat(RID_IFU, 32'hA0, 2'b00, 1'b0); chk_beat("il_i0", 1, 0, 0, 0, 32'hA0);
    beat(RID_LSU, 32'hB0, 2'b00, 1'b1); chk_beat("il_l0", 0, 1, 1, 0, 32'hB0);
    for (int i = 1; i < 4; i++) begin
      beat(RID_IFU, 32'hA0 + i, 2'b00, i == 3);
      chk_beat("il_i", 1, 0, i == 3, 0, 32'hA0 + i);
    end
    rclr();

    // Error cases: short burst, SLVERR, unknown RID, LSU overrun.
    grant(1'b0, 32'h5000, "ifu_short");
    beat(RID_IFU, 32'hE0, 2'b00, 1'b0); chk_beat("short_b0", 1, 0, 0, 0, 32'hE0);
    beat(RID_IFU, 32'hE1, 2'b00, 1'b1); chk_beat("short_b1", 1, 0, 1, 1, 32'hE1);
    rclr();
    grant(1'b1, 32'h6000, "lsu_slverr");
    beat(RID_LSU, 32'hE2, 2'b10, 1'b1); chk_beat("slverr", 0, 1, 1, 1, 32'hE2);
    beat(4'hF, 32'hE3, 2'b00, 1'b1); chk_beat("unk_rid", 0, 0, 0, 0, 32'h0);
    rclr();
    grant(1'b1, 32'h7000, "lsu_ovr");
    beat(RID_LSU, 32'hF0, 2'b00, 1'b0); chk_beat("ovr_b0", 0, 1, 0, 1, 32'hF0);
    beat(RID_LSU, 32'hF1, 2'b00, 1'b0); chk_beat("ovr_b1", 0, 1, 0, 1, 32'hF1);
    beat(RID_LSU, 32'hF2, 2'b00, 1'b1); chk_beat("ovr_b2", 0, 1, 1, 1, 32'hF2);
    beat(RID_LSU, 32'hF3, 2'b00, 1'b1); chk_beat("ovr_after", 0, 0, 0, 0, 32'h0);
    rclr();

    // Reset in the middle of an IFU burst.
    grant(1'b0, 32'h8000, "ifu_rst");
    beat(RID_IFU, 32'h90, 2'b00, 1'b0); chk_beat("rst_b0", 1, 0, 0, 0, 32'h90);
    cyc(); resetn = 1'b0; r_valid = 1'b0;
    cyc(); resetn = 1'b1;
    r_valid = 1'b1; r_id = RID_IFU; r_data = 32'h91; r_last = 1'b0; #2;
    chk("rst_mid_arv", ar_valid, 1'b0);
    chk_beat("rst_trail", 0, 0, 0, 0, 32'h0);
    chk("rst_mid_idata", ifu_data, 32'h0);
    rclr();
    grant(1'b0, 32'h9000, "ifu_fresh");
    beat(RID_IFU, 32'h99, 2'b00, 1'b0); chk_beat("fresh_b0", 1, 0, 0, 0, 32'h99);
    rclr();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1, "timeout");
  end

endmodule
